dmem_sram_bridge: RTL and testbench

Data-side bridge between the CPU pipeline's MEM stage and an SRAM-like data bus with split address/data handshakes. It turns each MEM-stage load/store into exactly one bus transaction and raises `stallreq_from_mem` until read data or write completion returns. It holds the returned data stable for as long as the MEM stage is frozen by any other stall. It also maps kseg0/kseg1 virtual addresses to physical addresses.

---
 rtl/dmem_sram_bridge.sv | 119 +++++++++++
 tb/tb_dmem_sram_bridge.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sram_bridge.sv
// MEM-stage to SRAM-like data bus bridge with split address/data handshakes.
// One bus transaction per load/store; holds load data while the pipeline is frozen.
module dmem_sram_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_excepttype,
    input  logic        mem_stall,
    output logic [31:0] mem_rdata,
    output logic        stallreq_from_mem,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        issue;
    logic [31:0] phys_addr;

    // kseg0/kseg1 fold onto the low 512 MB; everything else is identity.
    always_comb begin
        phys_addr = mem_addr;
        if (mem_addr[31:30] == 2'b10) begin
            phys_addr = {3'b000, mem_addr[28:0]};
        end
    end

    assign issue = (state_q == S_IDLE) & mem_en
                 & (mem_excepttype == 32'd0);

    always_comb begin
        state_d           = state_q;
        data_req          = 1'b0;
        data_wr           = wr_q;
        data_size         = size_q;
        data_addr         = addr_q;
        data_wdata        = wdata_q;
        stallreq_from_mem = 1'b0;
        mem_rdata         = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                data_req          = issue;
                data_wr           = mem_en & mem_we;
                data_size         = mem_en ? mem_size : 2'd0;
                data_addr         = mem_en ? phys_addr : 32'd0;
                data_wdata        = mem_en ? mem_wdata : 32'd0;
                stallreq_from_mem = issue;
                if (issue) begin
                    state_d = data_addr_ok ? S_DATA : S_ADDR;
                end
            end
            S_ADDR: begin
                data_req          = 1'b1;
                stallreq_from_mem = 1'b1;
                if (data_addr_ok) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                stallreq_from_mem = ~data_data_ok;
                if (data_data_ok) begin
                    mem_rdata = data_rdata;
                    state_d   = mem_stall ? S_HOLD : S_IDLE;
                end
            end
            S_HOLD: begin
                if (!mem_stall) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                wr_q    <= mem_we;
                size_q  <= mem_size;
                addr_q  <= phys_addr;
                wdata_q <= mem_wdata;
            end
            // Stores also land here; the value is simply unused.
            if (state_q == S_DATA && data_data_ok) begin
                rdata_q <= data_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed bench for dmem_sram_bridge.
// Inputs change 1 ns after posedge; outputs are sampled on negedge.
module tb_dmem_sram_bridge;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic [31:0] mem_wdata;
    logic [31:0] mem_excepttype;
    logic        mem_stall;
    logic [31:0] mem_rdata;
    logic        stallreq_from_mem;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_checks;
    int n_errors;
    int n_txn;
    int txn_base;

    dmem_sram_bridge dut (
        .clk               (clk),
        .rst               (rst),
        .mem_en            (mem_en),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_size          (mem_size),
        .mem_wdata         (mem_wdata),
        .mem_excepttype    (mem_excepttype),
        .mem_stall         (mem_stall),
        .mem_rdata         (mem_rdata),
        .stallreq_from_mem (stallreq_from_mem),
        .data_req          (data_req),
        .data_wr           (data_wr),
        .data_size         (data_size),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_addr_ok      (data_addr_ok),
        .data_data_ok      (data_data_ok),
        .data_rdata        (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && data_req && data_addr_ok) begin
            n_txn <= n_txn + 1;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = 32'd0;
        mem_size       = 2'd0;
        mem_wdata      = 32'd0;
        mem_excepttype = 32'd0;
        mem_stall      = 1'b0;
        data_addr_ok   = 1'b0;
        data_data_ok   = 1'b0;
        data_rdata     = 32'd0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_txn    = 0;
        idle_inputs();
        rst = 1'b1;
        #3;
        check("rst_req",   {31'd0, data_req}, 32'd0);
        check("rst_stall", {31'd0, stallreq_from_mem}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_addr",  data_addr, 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Load word kseg0, minimum latency
        mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'd2;
        mem_addr = 32'h8000_1004; data_addr_ok = 1'b1;
        @(negedge clk);
        check("lw_req",   {31'd0, data_req}, 32'd1);
        check("lw_addr",  data_addr, 32'h0000_1004);
        check("lw_wr",    {31'd0, data_wr}, 32'd0);
        check("lw_size",  {30'd0, data_size}, 32'd2);
        check("lw_stall", {31'd0, stallreq_from_mem}, 32'd1);
        next_cycle();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("lw_dok_stall", {31'd0, stallreq_from_mem}, 32'd0);
        check("lw_dok_req",   {31'd0, data_req}, 32'd0);
        check("lw_rdata",     mem_rdata, 32'hDEAD_BEEF);
        next_cycle();

        // Back-to-back useg load
        data_data_ok = 1'b0; data_rdata = 32'd0;
        mem_addr = 32'h0040_0000; data_addr_ok = 1'b1;
        @(negedge clk);
        check("b2b_req",   {31'd0, data_req}, 32'd1);
        check("useg_addr", data_addr, 32'h0040_0000);
        check("b2b_hold_rdata", mem_rdata, 32'hDEAD_BEEF);
        next_cycle();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h0BAD_CAFE;
        @(negedge clk);
        check("useg_rdata", mem_rdata, 32'h0BAD_CAFE);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("useg_after", mem_rdata, 32'h0BAD_CAFE);
        check("txn_two", n_txn, 32'd2);
        next_cycle();

        // Store byte kseg1, addr_ok delayed 3 cycles
        mem_en = 1'b1; mem_we = 1'b1; mem_size = 2'd0;
        mem_addr = 32'hBFC0_0003; mem_wdata = 32'h0000_5A00;
        for (int i = 0; i < 4; i++) begin
            data_addr_ok = (i == 3);
            @(negedge clk);
            check($sformatf("sb_req%0d", i),
                  {31'd0, data_req}, 32'd1);
            check($sformatf("sb_addr%0d", i),
                  data_addr, 32'h1FC0_0003);
            check($sformatf("sb_wr%0d", i),
                  {31'd0, data_wr}, 32'd1);
            check($sformatf("sb_size%0d", i),
                  {30'd0, data_size}, 32'd0);
            check($sformatf("sb_wdata%0d", i),
                  data_wdata, 32'h0000_5A00);
            check($sformatf("sb_stall%0d", i),
                  {31'd0, stallreq_from_mem}, 32'd1);
            next_cycle();
            mem_addr  = 32'h1234_5678;
            mem_wdata = 32'hFFFF_FFFF;
        end
        data_addr_ok = 1'b0;
        @(negedge clk);
        check("sb_wait_stall", {31'd0, stallreq_from_mem}, 32'd1);
        check("sb_wait_req",   {31'd0, data_req}, 32'd0);
        next_cycle();
        data_data_ok = 1'b1; data_rdata = 32'h0;
        @(negedge clk);
        check("sb_dok_stall", {31'd0, stallreq_from_mem}, 32'd0);
        next_cycle();
        idle_inputs();
        next_cycle();

        // Load followed by external stall: HOLD, no reissue
        txn_base = n_txn;
        mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'd2;
        mem_addr = 32'h8000_0010; data_addr_ok = 1'b1;
        next_cycle();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        data_rdata = 32'hCAFE_F00D; mem_stall = 1'b1;
        @(negedge clk);
        check("hold_dok_rdata", mem_rdata, 32'hCAFE_F00D);
        next_cycle();
        data_data_ok = 1'b0; data_rdata = 32'd0;
        for (int i = 0; i < 4; i++) begin
            mem_stall    = (i < 3);
            data_data_ok = (i == 1);
            data_addr_ok = (i == 1);
            data_rdata   = (i == 1) ? 32'h1111_1111 : 32'd0;
            @(negedge clk);
            check($sformatf("hold_req%0d", i),
                  {31'd0, data_req}, 32'd0);
            check($sformatf("hold_stall%0d", i),
                  {31'd0, stallreq_from_mem}, 32'd0);
            check($sformatf("hold_rdata%0d", i),
                  mem_rdata, 32'hCAFE_F00D);
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        check("hold_txn", n_txn - txn_base, 32'd1);
        check("hold_after_rdata", mem_rdata, 32'hCAFE_F00D);
        next_cycle();

        // Exception pending: store suppressed
        txn_base = n_txn;
        mem_en = 1'b1; mem_we = 1'b1; mem_size = 2'd2;
        mem_addr = 32'h8000_0001; mem_excepttype = 32'h5;
        data_addr_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("exc_req%0d", i),
                  {31'd0, data_req}, 32'd0);
            check($sformatf("exc_stall%0d", i),
                  {31'd0, stallreq_from_mem}, 32'd0);
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        check("exc_txn", n_txn - txn_base, 32'd0);
        next_cycle();

        // Reset while waiting in DATA
        mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'd2;
        mem_addr = 32'h0000_0200; data_addr_ok = 1'b1;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("data_wait_stall", {31'd0, stallreq_from_mem}, 32'd1);
        check("data_wait_rdata", mem_rdata, 32'hCAFE_F00D);
        #1;
        rst = 1'b1;
        #1;
        check("arst_stall", {31'd0, stallreq_from_mem}, 32'd0);
        check("arst_rdata", mem_rdata, 32'd0);
        check("arst_req",   {31'd0, data_req}, 32'd0);
        #1;
        rst = 1'b0;
        next_cycle();
        data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
        @(negedge clk);
        check("post_rst_ignore", mem_rdata, 32'd0);
        next_cycle();
        idle_inputs();
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
